// File: rtl/core_fetch_ctrl.sv
// Instruction-fetch control: owns the fetch PC, keeps one imem request in flight, buffers one instruction for decode.
// Optional statistics counters are enabled with `define CORE_FETCH_STATS_EN.
module core_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_err
`ifdef CORE_FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_dropped
`endif
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_if_pc, r_if_instr;
  logic        r_if_err;
  logic        w_capture, w_drop_evt, w_fetch_evt;

  assign imem_req_valid = (r_state == ST_REQ) && rst_n;
  assign imem_req_addr  = r_pc;
  assign if_valid       = (r_state == ST_HOLD);
  assign if_pc          = r_if_pc;
  assign if_instr       = r_if_instr;
  assign if_err         = r_if_err;

  // Next-state, next-PC and event decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    w_drop_evt  = 1'b0;
    w_fetch_evt = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (imem_req_valid && imem_req_ready) begin
          w_state_nxt = redirect_valid ? ST_DROP : ST_WAIT;
        end else begin
          w_state_nxt = ST_REQ;
        end
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid && !redirect_valid) begin
          w_capture   = 1'b1;
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = ST_HOLD;
        end else if (imem_rsp_valid) begin
          w_drop_evt  = 1'b1;
          w_pc_nxt    = redirect_pc;
          w_state_nxt = ST_REQ;
        end else if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = ST_DROP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DROP: begin
        // A stale response is still owed; later redirects only retarget the PC.
        if (imem_rsp_valid) begin
          w_drop_evt  = 1'b1;
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_DROP;
        end
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          w_drop_evt  = 1'b1;
          w_pc_nxt    = redirect_pc;
          w_state_nxt = ST_REQ;
        end else if (if_ready) begin
          w_fetch_evt = 1'b1;
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_REQ;
      end
    endcase
  end

  // State and fetch PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_REQ;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Decode-side instruction buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_pc    <= 32'd0;
      r_if_instr <= 32'd0;
      r_if_err   <= 1'b0;
    end else if (w_capture) begin
      r_if_pc    <= r_pc;
      r_if_instr <= imem_rsp_data;
      r_if_err   <= imem_rsp_err;
    end else begin
      r_if_pc    <= r_if_pc;
      r_if_instr <= r_if_instr;
      r_if_err   <= r_if_err;
    end
  end

`ifdef CORE_FETCH_STATS_EN
  logic [31:0] r_stat_fetched, r_stat_dropped;

  assign stat_fetched = r_stat_fetched;
  assign stat_dropped = r_stat_dropped;

  // Delivered and discarded instruction counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_fetched <= 32'd0;
      r_stat_dropped <= 32'd0;
    end else begin
      r_stat_fetched <= r_stat_fetched + (w_fetch_evt ? 32'd1 : 32'd0);
      r_stat_dropped <= r_stat_dropped + (w_drop_evt ? 32'd1 : 32'd0);
    end
  end
`else
  logic w_unused_evt;
  assign w_unused_evt = w_fetch_evt ^ w_drop_evt;
`endif

endmodule

// File: tb/tb_core_fetch_ctrl.sv
// Randomized bench for core_fetch_ctrl: transaction-level fetch model plus a variable-latency memory model.
module tb_core_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        imem_rsp_err = 1'b0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_err;
`ifdef CORE_FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_dropped;
  logic [31:0] m_fetched, m_dropped;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: PC, one in-flight request (possibly wrong-path), one buffered instruction.
  logic [31:0] m_pc;
  bit          m_out, m_stale, m_buf_v;
  logic [31:0] m_buf_pc, m_buf_instr;
  bit          m_buf_err;

  // Memory model: one pending response after a random delay.
  bit          mem_busy;
  int          mem_cnt;
  int          lat_max;
  logic [31:0] mem_data;
  bit          mem_err;

  core_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr), .if_err(if_err)
`ifdef CORE_FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_dropped(stat_dropped)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit exp_req;
    exp_req = !m_out && !m_buf_v && (rst_n == 1'b1);
    check_eq("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
    check_eq("req_addr", imem_req_addr, m_pc);
    check_eq("if_valid", {31'd0, if_valid}, {31'd0, m_buf_v});
    check_eq("if_pc", if_pc, m_buf_pc);
    check_eq("if_instr", if_instr, m_buf_instr);
    check_eq("if_err", {31'd0, if_err}, {31'd0, m_buf_err});
`ifdef CORE_FETCH_STATS_EN
    check_eq("stat_fetched", stat_fetched, m_fetched);
    check_eq("stat_dropped", stat_dropped, m_dropped);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0; imem_req_ready = 1'b0; if_ready = 1'b0; imem_rsp_valid = 1'b0;
    m_pc = RST_PC; m_out = 1'b0; m_stale = 1'b0; m_buf_v = 1'b0;
    m_buf_pc = 32'd0; m_buf_instr = 32'd0; m_buf_err = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0;
`ifdef CORE_FETCH_STATS_EN
    m_fetched = 32'd0; m_dropped = 32'd0;
`endif
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy, input bit ifr);
    bit rsp, exp_req;
    logic [31:0] old_pc;
    @(negedge clk);
    rsp = mem_busy && (mem_cnt == 0);
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    if_ready       = ifr;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_data : $urandom;
    imem_rsp_err   = rsp ? mem_err : 1'($urandom);
    #1;
    check_outputs();
    exp_req = !m_out && !m_buf_v;
    old_pc  = m_pc;
    if (m_buf_v) begin
      if (redir) begin
        m_buf_v = 1'b0; m_pc = rpc;
`ifdef CORE_FETCH_STATS_EN
        m_dropped++;
`endif
      end else if (ifr) begin
        m_buf_v = 1'b0;
`ifdef CORE_FETCH_STATS_EN
        m_fetched++;
`endif
      end
    end else if (!m_out) begin
      if (rdy) begin
        m_out = 1'b1; m_stale = redir;
      end
      if (redir) m_pc = rpc;
    end else if (rsp) begin
      m_out = 1'b0;
      if (m_stale || redir) begin
`ifdef CORE_FETCH_STATS_EN
        m_dropped++;
`endif
      end else begin
        m_buf_v = 1'b1; m_buf_pc = m_pc; m_buf_instr = imem_rsp_data; m_buf_err = imem_rsp_err;
        m_pc = m_pc + 32'd4;
      end
      if (redir) m_pc = rpc;
    end else if (redir) begin
      m_stale = 1'b1; m_pc = rpc;
    end
    if (rsp) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (exp_req && rdy) begin
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(0, lat_max);
      mem_data = old_pc ^ $urandom;
      mem_err  = ($urandom_range(0, 3) == 0);
    end
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    t = $urandom;
    case ($urandom_range(0, 3))
      0: pick_target = 32'hFFFF_FFF8;
      1: pick_target = 32'h8000_0100;
      default: pick_target = t & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    lat_max = 0;
    do_reset();
    repeat (12) cycle(1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    repeat (12) cycle(1'b0, 32'd0, 1'b1, 1'b1);
    lat_max = 3;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      cycle($urandom_range(0, 7) == 0, pick_target(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
